// File: rtl/pll_dyn_ctrl.sv
// Dynamic-divider sequencer for a Gowin rPLL: applies a preset divider set,
// pulses RESET, qualifies LOCK and hands a clean reset to the pixel domain.
`timescale 1ns/1ps
module pll_dyn_ctrl #(
  parameter int                     NUM_MODES    = 2,
  parameter logic [NUM_MODES*6-1:0] IDIV_TABLE   = {6'd2, 6'd2},
  parameter logic [NUM_MODES*6-1:0] FBDIV_TABLE  = {6'd13, 6'd13},
  parameter logic [NUM_MODES*6-1:0] ODSEL_TABLE  = {6'd62, 6'd60},
  parameter int                     RESET_CYCLES = 16,
  parameter int                     LOCK_FILTER  = 64,
  parameter int                     LOCK_TIMEOUT = 65535,
  parameter int                     MAX_RETRY    = 3
) (
  input  logic       clkin,
  input  logic       resetn,
  input  logic [2:0] mode_sel,
  input  logic       mode_req,
  output logic       mode_ack,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic [5:0] idsel,
  output logic [5:0] fbdsel,
  output logic [5:0] odsel,
  output logic       ready,
  output logic       pix_resetn,
  output logic [2:0] active_mode,
  output logic [1:0] retry_cnt,
  output logic       error
);

  typedef enum logic [2:0] {S_RST_HOLD, S_WAIT_LOCK, S_FILTER, S_RUN, S_ERROR} state_t;

  localparam logic [5:0] ID0  = 6'd63 - IDIV_TABLE[5:0];
  localparam logic [5:0] FB0  = 6'd63 - FBDIV_TABLE[5:0];
  localparam logic [5:0] OD0  = ODSEL_TABLE[5:0];
  localparam logic [2:0] LAST = 3'(NUM_MODES - 1);

  // Encoded tables padded to 8 entries so a 3-bit index is always in range.
  logic [5:0] id_tab [8];
  logic [5:0] fb_tab [8];
  logic [5:0] od_tab [8];

  for (genvar g = 0; g < 8; g++) begin : g_tab
    if (g < NUM_MODES) begin : g_used
      assign id_tab[g] = 6'd63 - IDIV_TABLE[6*g +: 6];
      assign fb_tab[g] = 6'd63 - FBDIV_TABLE[6*g +: 6];
      assign od_tab[g] = ODSEL_TABLE[6*g +: 6];
    end else begin : g_unused
      assign id_tab[g] = '0;
      assign fb_tab[g] = '0;
      assign od_tab[g] = '0;
    end
  end

  state_t      state_q;
  logic [31:0] cnt_q, filt_q;
  logic        meta_q, lock_s_q;
  logic        mode_ack_q, pll_reset_q, run_q, pix_q, err_q;
  logic [1:0]  retry_q;
  logic [2:0]  mode_q;
  logic [5:0]  idsel_q, fbdsel_q, odsel_q;

  logic       accept, ready_c;
  logic [2:0] sel_c;

  assign accept  = mode_req & ~mode_ack_q;
  assign sel_c   = (int'(mode_sel) >= NUM_MODES) ? LAST : mode_sel;
  // Lock loss in RUN must pull ready down in the very cycle lock_s falls.
  assign ready_c = run_q & lock_s_q;

  // LOCK is meaningless while the PLL is held in reset, so the synchroniser
  // is flushed then; this also makes the lock latency deterministic.
  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      meta_q   <= 1'b0;
      lock_s_q <= 1'b0;
    end else if (pll_reset_q) begin
      meta_q   <= 1'b0;
      lock_s_q <= 1'b0;
    end else begin
      meta_q   <= pll_lock;
      lock_s_q <= meta_q;
    end
  end

  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_RST_HOLD;
      cnt_q       <= '0;
      filt_q      <= '0;
      mode_ack_q  <= 1'b0;
      pll_reset_q <= 1'b1;
      run_q       <= 1'b0;
      pix_q       <= 1'b0;
      err_q       <= 1'b0;
      retry_q     <= '0;
      mode_q      <= '0;
      idsel_q     <= ID0;
      fbdsel_q    <= FB0;
      odsel_q     <= OD0;
    end else begin
      mode_ack_q <= accept;
      pix_q      <= ready_c;
      if (accept) begin
        state_q     <= S_RST_HOLD;
        cnt_q       <= '0;
        filt_q      <= '0;
        pll_reset_q <= 1'b1;
        run_q       <= 1'b0;
        err_q       <= 1'b0;
        mode_q      <= sel_c;
        idsel_q     <= id_tab[sel_c];
        fbdsel_q    <= fb_tab[sel_c];
        odsel_q     <= od_tab[sel_c];
        if (state_q == S_ERROR) retry_q <= '0;
      end else begin
        case (state_q)
          S_RST_HOLD: begin
            if (cnt_q == 32'(RESET_CYCLES - 1)) begin
              state_q     <= S_WAIT_LOCK;
              cnt_q       <= '0;
              pll_reset_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q + 32'd1;
            end
          end
          S_WAIT_LOCK: begin
            if (lock_s_q) begin
              state_q <= S_FILTER;
              filt_q  <= '0;
            end else if (cnt_q >= 32'(LOCK_TIMEOUT - 1)) begin
              pll_reset_q <= 1'b1;
              if (retry_q == 2'(MAX_RETRY)) begin
                state_q <= S_ERROR;
                err_q   <= 1'b1;
              end else begin
                state_q <= S_RST_HOLD;
                cnt_q   <= '0;
                retry_q <= retry_q + 2'd1;
              end
            end else begin
              cnt_q <= cnt_q + 32'd1;
            end
          end
          // Timeout counter is frozen here and resumes if lock bounces.
          S_FILTER: begin
            if (!lock_s_q) begin
              state_q <= S_WAIT_LOCK;
            end else if (filt_q == 32'(LOCK_FILTER - 1)) begin
              state_q <= S_RUN;
              run_q   <= 1'b1;
              retry_q <= '0;
            end else begin
              filt_q <= filt_q + 32'd1;
            end
          end
          S_RUN: begin
            if (!lock_s_q) begin
              state_q     <= S_RST_HOLD;
              cnt_q       <= '0;
              pll_reset_q <= 1'b1;
              run_q       <= 1'b0;
            end
          end
          S_ERROR: pll_reset_q <= 1'b1;
          default: begin
            state_q     <= S_RST_HOLD;
            cnt_q       <= '0;
            pll_reset_q <= 1'b1;
            run_q       <= 1'b0;
          end
        endcase
      end
    end
  end

  assign mode_ack    = mode_ack_q;
  assign pll_reset   = pll_reset_q;
  assign idsel       = idsel_q;
  assign fbdsel      = fbdsel_q;
  assign odsel       = odsel_q;
  assign ready       = ready_c;
  assign pix_resetn  = pix_q;
  assign active_mode = mode_q;
  assign retry_cnt   = retry_q;
  assign error       = err_q;

endmodule

// File: tb/tb_pll_dyn_ctrl.sv
// Scoreboard bench for pll_dyn_ctrl: stimulus queues every expected output
// change with its cycle; the monitor pops and compares on each observed change.
`timescale 1ns/1ps
module tb_pll_dyn_ctrl;

  typedef struct packed {
    logic       pll_reset;
    logic       ready;
    logic       pix;
    logic       ack;
    logic       err;
    logic [1:0] retry;
    logic [2:0] mode;
    logic [5:0] id;
    logic [5:0] fb;
    logic [5:0] od;
  } snap_t;

  typedef struct {
    int    c;
    snap_t s;
  } ev_t;

  logic       clkin = 1'b0;
  logic       resetn = 1'b1;
  logic [2:0] mode_sel = 3'd0;
  logic       mode_req = 1'b0;
  logic       pll_lock = 1'b1;
  logic       mode_ack, pll_reset, ready, pix_resetn, error;
  logic [5:0] idsel, fbdsel, odsel;
  logic [2:0] active_mode;
  logic [1:0] retry_cnt;

  always #5 clkin = ~clkin;

  // Preset 0 -> odsel 62, preset 1 -> odsel 60.
  pll_dyn_ctrl #(
    .NUM_MODES   (2),
    .IDIV_TABLE  ({6'd2, 6'd2}),
    .FBDIV_TABLE ({6'd13, 6'd13}),
    .ODSEL_TABLE ({6'd60, 6'd62}),
    .RESET_CYCLES(16),
    .LOCK_FILTER (64),
    .LOCK_TIMEOUT(100),
    .MAX_RETRY   (3)
  ) dut (
    .clkin      (clkin),
    .resetn     (resetn),
    .mode_sel   (mode_sel),
    .mode_req   (mode_req),
    .mode_ack   (mode_ack),
    .pll_lock   (pll_lock),
    .pll_reset  (pll_reset),
    .idsel      (idsel),
    .fbdsel     (fbdsel),
    .odsel      (odsel),
    .ready      (ready),
    .pix_resetn (pix_resetn),
    .active_mode(active_mode),
    .retry_cnt  (retry_cnt),
    .error      (error)
  );

  int    cyc = 0;
  always @(posedge clkin) cyc <= cyc + 1;

  ev_t   evq[$];
  snap_t exp_s, cur_s, prev_s;
  ev_t   ev;
  int    n_chk = 0, n_fail = 0;
  int    probe_cnt = 0, probe_seen = 0;
  bit    started = 0, done = 0, mon_init = 0;

  localparam snap_t RST = '{pll_reset: 1'b1, ready: 1'b0, pix: 1'b0, ack: 1'b0, err: 1'b0,
                            retry: 2'd0, mode: 3'd0, id: 6'd61, fb: 6'd50, od: 6'd62};

  function automatic snap_t get_snap();
    snap_t s;
    s.pll_reset = pll_reset;
    s.ready     = ready;
    s.pix       = pix_resetn;
    s.ack       = mode_ack;
    s.err       = error;
    s.retry     = retry_cnt;
    s.mode      = active_mode;
    s.id        = idsel;
    s.fb        = fbdsel;
    s.od        = odsel;
    return s;
  endfunction

  task automatic push(input int c);
    ev_t e;
    e.c = c;
    e.s = exp_s;
    evq.push_back(e);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clkin);
  endtask

  // Monitor: every output change (or explicit probe) consumes one expected event.
  always @(negedge clkin) begin
    if (started) begin
      cur_s = get_snap();
      if (!mon_init) begin
        prev_s   = cur_s;
        mon_init = 1;
      end
      if (cur_s !== prev_s || probe_cnt != probe_seen) begin
        if (probe_cnt != probe_seen) probe_seen++;
        n_chk++;
        if (evq.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_change cyc=%0d got=%h", cyc, cur_s);
        end else begin
          ev = evq.pop_front();
          if (ev.c != cyc || ev.s !== cur_s) begin
            n_fail++;
            $display("FAIL out_event cyc=%0d exp_cyc=%0d got=%h exp=%h", cyc, ev.c, cur_s, ev.s);
          end
        end
        prev_s = cur_s;
      end
      if (done) begin
        n_chk++;
        if (evq.size() != 0) begin
          n_fail++;
          $display("FAIL pending_events got=%0d exp=0 next_cyc=%0d", evq.size(), evq[0].c);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d exp=finish_before_timeout", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int r, d, m, n, t;
    #2 resetn = 1'b0;
    repeat (3) @(negedge clkin);
    started = 1;
    @(posedge clkin); #2;
    exp_s = RST;
    push(cyc);
    probe_cnt++;

    // Reset release with lock tied high
    @(negedge clkin);
    r = cyc;
    resetn = 1'b1;
    exp_s.pll_reset = 1'b0; push(r + 16);
    exp_s.ready     = 1'b1; push(r + 83);
    exp_s.pix       = 1'b1; push(r + 84);
    wait_cyc(r + 90);

    // Lock loss in RUN, then a one-cycle glitch 40 cycles into FILTER
    d = cyc;
    pll_lock = 1'b0;
    exp_s.ready = 1'b0; push(d + 2);
    exp_s.pll_reset = 1'b1; exp_s.pix = 1'b0; push(d + 3);
    exp_s.pll_reset = 1'b0; push(d + 19);
    exp_s.ready = 1'b1; push(d + 130);
    exp_s.pix   = 1'b1; push(d + 131);
    wait_cyc(d + 3);  pll_lock = 1'b1;
    wait_cyc(d + 62); pll_lock = 1'b0;
    wait_cyc(d + 63); pll_lock = 1'b1;
    wait_cyc(d + 140);

    // Mode switch to preset 1 from RUN
    m = cyc;
    mode_sel = 3'd1; mode_req = 1'b1;
    exp_s.pll_reset = 1'b1; exp_s.ready = 1'b0; exp_s.ack = 1'b1;
    exp_s.mode = 3'd1; exp_s.od = 6'd60; push(m + 1);
    exp_s.ack = 1'b0; exp_s.pix = 1'b0; push(m + 2);
    exp_s.pll_reset = 1'b0; push(m + 17);
    exp_s.ready = 1'b1; push(m + 84);
    exp_s.pix   = 1'b1; push(m + 85);
    wait_cyc(m + 1); mode_req = 1'b0;
    wait_cyc(m + 95);

    // Switch to preset 0, then mid-hold request for 5 (clamped to 1) restarts the hold
    n = cyc;
    mode_sel = 3'd0; mode_req = 1'b1;
    exp_s.pll_reset = 1'b1; exp_s.ready = 1'b0; exp_s.ack = 1'b1;
    exp_s.mode = 3'd0; exp_s.od = 6'd62; push(n + 1);
    exp_s.ack = 1'b0; exp_s.pix = 1'b0; push(n + 2);
    exp_s.ack = 1'b1; exp_s.mode = 3'd1; exp_s.od = 6'd60; push(n + 7);
    exp_s.ack = 1'b0; push(n + 8);
    exp_s.pll_reset = 1'b0; push(n + 23);
    exp_s.ready = 1'b1; push(n + 90);
    exp_s.pix   = 1'b1; push(n + 91);
    wait_cyc(n + 1); mode_req = 1'b0;
    wait_cyc(n + 6); mode_sel = 3'd5; mode_req = 1'b1;
    wait_cyc(n + 7); mode_req = 1'b0;
    wait_cyc(n + 100);

    // Lock lost for good: three retries, then ERROR
    t = cyc;
    pll_lock = 1'b0;
    exp_s.ready = 1'b0; push(t + 2);
    exp_s.pll_reset = 1'b1; exp_s.pix = 1'b0; push(t + 3);
    for (int k = 0; k < 4; k++) begin
      exp_s.pll_reset = 1'b0; push(t + 19 + 116*k);
      exp_s.pll_reset = 1'b1;
      if (k < 3) exp_s.retry = 2'(k + 1);
      else       exp_s.err   = 1'b1;
      push(t + 119 + 116*k);
    end
    wait_cyc(t + 480);

    // Mode request clears ERROR and relocks
    mode_sel = 3'd1; mode_req = 1'b1; pll_lock = 1'b1;
    exp_s.err = 1'b0; exp_s.retry = 2'd0; exp_s.ack = 1'b1; push(t + 481);
    exp_s.ack = 1'b0; push(t + 482);
    exp_s.pll_reset = 1'b0; push(t + 497);
    wait_cyc(t + 481); mode_req = 1'b0;

    // Asynchronous reset in the middle of FILTER
    wait_cyc(t + 529);
    @(posedge clkin); #2;
    exp_s = RST; push(cyc);
    resetn = 1'b0;
    wait_cyc(t + 535);
    resetn = 1'b1;
    exp_s.pll_reset = 1'b0; push(t + 551);
    exp_s.ready     = 1'b1; push(t + 618);
    exp_s.pix       = 1'b1; push(t + 619);
    wait_cyc(t + 630);
    done = 1;
  end

endmodule

// File: doc/pll_dyn_ctrl.md
Name: pll_dyn_ctrl

Overview:
- Sequencer for a Gowin rPLL used in dynamic-divider mode (DYN_IDIV_SEL/DYN_FBDIV_SEL/DYN_ODIV_SEL = "true").
- Selects one of NUM_MODES preset divider sets, drives IDSEL/FBDSEL/ODSEL, pulses the PLL RESET, qualifies LOCK, and releases a downstream pixel-domain reset.
- Handles runtime mode switches, lock loss and lock timeout with bounded retries.
- Sits between the video top level and the rPLL primitive in the DVI examples.

Parameters:
- NUM_MODES, 2: number of divider presets (1..8).
- IDIV_TABLE, {6'd2, 6'd2}: packed NUM_MODES×6 IDIV_SEL values; entry k is bits [6k+5:6k].
- FBDIV_TABLE, {6'd13, 6'd13}: packed FBDIV_SEL values.
- ODSEL_TABLE, {6'd62, 6'd60}: packed raw ODSEL codes, passed through unencoded.
- RESET_CYCLES, 16: PLL reset hold length, in clkin cycles (≥2).
- LOCK_FILTER, 64: consecutive synchronised-lock-high cycles required before declaring lock.
- LOCK_TIMEOUT, 65535: maximum cycles in WAIT_LOCK.
- MAX_RETRY, 3: timeout retries before entering ERROR.

Ports:
- clkin, input, 1: reference clock; all logic runs on it.
- resetn, input, 1: asynchronous active-low reset.
- mode_sel, input, 3: requested preset index; sampled when mode_req is accepted.
- mode_req, input, 1: mode-change request; level-held until mode_ack.
- mode_ack, output, 1: one-cycle acceptance pulse.
- pll_lock, input, 1: rPLL LOCK, asynchronous.
- pll_reset, output, 1: to rPLL RESET; active high.
- idsel, output, 6: rPLL IDSEL.
- fbdsel, output, 6: rPLL FBDSEL.
- odsel, output, 6: rPLL ODSEL.
- ready, output, 1: PLL locked and qualified.
- pix_resetn, output, 1: downstream active-low reset; equals ready, registered.
- active_mode, output, 3: currently applied preset index.
- retry_cnt, output, 2: timeouts since the last successful lock.
- error, output, 1: sticky; retries exhausted.

Behaviour:
Reset values (async, resetn low):
- State RST_HOLD, pll_reset=1, ready=0, pix_resetn=0, mode_ack=0, error=0, retry_cnt=0, active_mode=0.
- Divider outputs load preset 0.

Encoding and input handling:
- idsel = 63 − IDIV_TABLE[k]; fbdsel = 63 − FBDIV_TABLE[k]; both 6-bit unsigned.
- odsel = ODSEL_TABLE[k], raw.
- Divider outputs change only while pll_reset=1.
- pll_lock passes through a 2-flop synchroniser. lock_s is the synchronised value; all lock decisions use lock_s.

States:
- RST_HOLD: pll_reset=1; counter runs RESET_CYCLES cycles, then WAIT_LOCK with the counter cleared.
- WAIT_LOCK: pll_reset=0.
  - lock_s=1 → FILTER.
  - Counter reaches LOCK_TIMEOUT → retry_cnt+1, then RST_HOLD.
  - If retry_cnt already equals MAX_RETRY → ERROR instead.
- FILTER: counts consecutive lock_s=1 cycles.
  - Any lock_s=0 → back to WAIT_LOCK; the timeout counter is not cleared.
  - Count reaches LOCK_FILTER → RUN with retry_cnt cleared.
- RUN: ready=1.
  - lock_s=0 → ready=0 the same cycle, then RST_HOLD.
  - This relock path does not increment retry_cnt.
- ERROR: pll_reset=1, ready=0, error=1. Leaves only via resetn or an accepted mode_req; the latter clears error and retry_cnt.

Mode handshake:
- mode_req is accepted in any state when mode_ack was 0 in the previous cycle.
- On acceptance:
  - If mode_sel ≥ NUM_MODES, it is clamped to NUM_MODES−1.
  - mode_ack pulses for 1 cycle.
  - ready drops in the same cycle.
  - active_mode and the divider outputs update.
  - The FSM goes to RST_HOLD with the counter cleared.
- A request during RST_HOLD restarts the hold count.
- A request equal to active_mode still performs a full relock.

pix_resetn:
- Registered copy of ready, so it lags ready by 1 cycle on both assert and deassert.

Latency (clean lock, lock high before release):
- From RST_HOLD exit to ready=1 takes 2 sync cycles + 1 + LOCK_FILTER cycles.

Test Plan:
- Reset release, pll_lock tied 1, defaults:
  - pll_reset high for 16 cycles; idsel=61, fbdsel=50, odsel=62.
  - ready rises 67 cycles after pll_reset falls; pix_resetn rises 1 cycle later.
- Lock glitch low for 1 cycle mid-FILTER (after 40 good cycles) → filter restarts; ready is delayed by the full 64 good cycles after the glitch.
- RUN, pll_lock drops → ready=0 the cycle lock_s falls, pll_reset=1 for 16 cycles, relock follows, retry_cnt stays 0.
- pll_lock held 0, LOCK_TIMEOUT=100 (test override):
  - Three timeouts give retry_cnt 1, 2, 3.
  - The fourth timeout enters ERROR with error=1 and pll_reset=1.
  - mode_req then clears error and relocks.
- mode_sel=1 with mode_req in RUN → 1-cycle mode_ack; ready=0; odsel=60, active_mode=1; relock sequence follows.
- mode_sel=5 with NUM_MODES=2 → clamped, active_mode=1.
- resetn asserted mid-FILTER → all outputs return to reset values asynchronously.
